// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned BUS_W = 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic CORE = 1'b0;
    localparam logic HOST = 1'b1;

    localparam logic [BUS_W-1:0] OE_ON  = '1;
    localparam logic [BUS_W-1:0] OE_OFF = '0;

    // Request payload latched at grant time.
    typedef struct packed {
        logic             we;
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] wdata;
    } xfer_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester, memory-side and status signals of the memory bus arbiter.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic             ena;
    logic             c_req;
    logic             c_we;
    logic [BUS_W-1:0] c_addr;
    logic [BUS_W-1:0] c_wdata;
    logic             c_ack;
    logic [BUS_W-1:0] c_rdata;
    logic             h_req;
    logic             h_we;
    logic [BUS_W-1:0] h_addr;
    logic [BUS_W-1:0] h_wdata;
    logic             h_ack;
    logic [BUS_W-1:0] h_rdata;
    logic [BUS_W-1:0] mem_addr;
    logic [BUS_W-1:0] mem_wdata;
    logic [BUS_W-1:0] mem_rdata;
    logic [BUS_W-1:0] mem_oe;
    logic             busy;
    logic             gnt_id;

    modport slave (
        input  ena, c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata, mem_rdata,
        output c_ack, c_rdata, h_ack, h_rdata, mem_addr, mem_wdata, mem_oe, busy, gnt_id
    );

    modport master (
        output ena, c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata, mem_rdata,
        input  c_ack, c_rdata, h_ack, h_rdata, mem_addr, mem_wdata, mem_oe, busy, gnt_id
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: on contention the requester not granted last wins.
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
(
    input  logic req_core,
    input  logic req_host,
    input  logic last_gnt,
    output logic winner_c
);

    always_comb begin
        winner_c = CORE;
        if (req_core && req_host) begin
            winner_c = ~last_gnt;
        end else if (req_host) begin
            winner_c = HOST;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates core and host requests onto one external memory bus,
// one transaction at a time: IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> DONE.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic              clk,
    input logic              rst_n,
    mem_bus_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             gnt_q, gnt_d;
    xfer_t            xfer_q, xfer_d;
    logic             c_ack_q, c_ack_d;
    logic             h_ack_q, h_ack_d;
    logic [BUS_W-1:0] c_rdata_q, c_rdata_d;
    logic [BUS_W-1:0] h_rdata_q, h_rdata_d;
    logic [BUS_W-1:0] mem_oe_q, mem_oe_d;
    logic             busy_q, busy_d;
    logic             winner_c;

    rr_arbiter2 u_rr (
        .req_core (bus.c_req),
        .req_host (bus.h_req),
        .last_gnt (last_q),
        .winner_c (winner_c)
    );

    // Next state, latched request and registered outputs derived from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        xfer_d    = xfer_q;
        c_rdata_d = c_rdata_q;
        h_rdata_d = h_rdata_q;
        c_ack_d   = 1'b0;
        h_ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ena && (bus.c_req || bus.h_req)) begin
                    gnt_d   = winner_c;
                    last_d  = winner_c;
                    xfer_d  = (winner_c == HOST)
                            ? '{we: bus.h_we, addr: bus.h_addr, wdata: bus.h_wdata}
                            : '{we: bus.c_we, addr: bus.c_addr, wdata: bus.c_wdata};
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = WAIT_LOAD;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Exit at one rather than zero so the counter never wraps.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                    if (!xfer_q.we) begin
                        if (gnt_q == HOST) begin
                            h_rdata_d = bus.mem_rdata;
                        end else begin
                            c_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d   = (state_d != ST_IDLE);
        mem_oe_d = (((state_d == ST_SETUP) || (state_d == ST_ACCESS)) && xfer_d.we) ? OE_ON : OE_OFF;
        if (state_d == ST_DONE) begin
            c_ack_d = (gnt_d == CORE);
            h_ack_d = (gnt_d == HOST);
        end
    end

    // Reset leaves the pointer on HOST so the first contended grant goes to core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= HOST;
            gnt_q     <= CORE;
            xfer_q    <= '0;
            c_ack_q   <= 1'b0;
            h_ack_q   <= 1'b0;
            c_rdata_q <= '0;
            h_rdata_q <= '0;
            mem_oe_q  <= OE_OFF;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            xfer_q    <= xfer_d;
            c_ack_q   <= c_ack_d;
            h_ack_q   <= h_ack_d;
            c_rdata_q <= c_rdata_d;
            h_rdata_q <= h_rdata_d;
            mem_oe_q  <= mem_oe_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.c_ack     = c_ack_q;
    assign bus.h_ack     = h_ack_q;
    assign bus.c_rdata   = c_rdata_q;
    assign bus.h_rdata   = h_rdata_q;
    assign bus.mem_addr  = xfer_q.addr;
    assign bus.mem_wdata = xfer_q.wdata;
    assign bus.mem_oe    = mem_oe_q;
    assign bus.busy      = busy_q;
    assign bus.gnt_id    = gnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: transaction-level model predicts grants, ack cycles and read data.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int W  = 1;
    localparam int W3 = 3;

    logic clk;
    logic rst_n;

    mem_bus_arbiter_if bus ();
    mem_bus_arbiter_if bus3 ();

    mem_bus_arbiter #(.WAIT_CYCLES(W))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mem_bus_arbiter #(.WAIT_CYCLES(W3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Memory read data is a known function of the cycle so the model can predict captures.
    int         cyc = 0;
    bit         fix_en = 1'b0;
    logic [7:0] fix_val = 8'h00;
    logic [7:0] seed = 8'h00;

    function automatic logic [7:0] mem_fn(input int c);
        if (fix_en) return fix_val;
        return 8'((c * 73 + 11) ^ (c >>> 2)) ^ seed;
    endfunction

    typedef struct {
        logic       who;
        int         ack_edge;
        logic [7:0] c_rd;
        logic [7:0] h_rd;
    } exp_t;

    exp_t       exp_q[$];
    logic       m_last = 1'b1;
    logic       m_gnt = 1'b0;
    logic       m_we = 1'b0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_c_rd = 8'h00;
    logic [7:0] m_h_rd = 8'h00;
    int         m_start = -100;
    int         m_next_free = 0;
    logic [7:0] vis_c = 8'h00;
    logic [7:0] vis_h = 8'h00;

    // Reference model: a grant occupies W+3 cycles; ack W+1 edges after the grant edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = 1'b1; m_gnt = 1'b0; m_we = 1'b0;
            m_addr = 8'h00; m_wdata = 8'h00; m_c_rd = 8'h00; m_h_rd = 8'h00;
            m_start = -100; m_next_free = 0;
            exp_q.delete();
        end else begin
            cyc++;
            if (cyc >= m_next_free && bus.ena && (bus.c_req || bus.h_req)) begin
                m_gnt       = (bus.c_req && bus.h_req) ? ~m_last : bus.h_req;
                m_last      = m_gnt;
                m_we        = m_gnt ? bus.h_we    : bus.c_we;
                m_addr      = m_gnt ? bus.h_addr  : bus.c_addr;
                m_wdata     = m_gnt ? bus.h_wdata : bus.c_wdata;
                m_start     = cyc;
                m_next_free = cyc + W + 3;
                if (!m_we) begin
                    if (m_gnt) m_h_rd = mem_fn(cyc + W);
                    else       m_c_rd = mem_fn(cyc + W);
                end
                exp_q.push_back('{who: m_gnt, ack_edge: cyc + W + 1, c_rd: m_c_rd, h_rd: m_h_rd});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            bus.mem_rdata = mem_fn(cyc);
        end
    end

    // Monitor: per-cycle bus checks plus scoreboard pop on every ack.
    always @(negedge clk) begin
        if (!rst_n) begin
            vis_c = 8'h00;
            vis_h = 8'h00;
            chk("reset_ctrl", 32'({bus.c_ack, bus.h_ack, bus.busy, bus.gnt_id, bus.mem_oe}), 32'(0));
            chk("reset_data", {bus.mem_addr, bus.mem_wdata, bus.c_rdata, bus.h_rdata}, 32'(0));
        end else begin
            chk("busy", 32'(bus.busy), 32'((cyc >= m_start) && (cyc <= m_start + W + 1)));
            chk("mem_oe", 32'(bus.mem_oe),
                (m_we && (cyc >= m_start) && (cyc <= m_start + W)) ? 32'hFF : 32'h00);
            chk("mem_addr_wdata", 32'({bus.mem_addr, bus.mem_wdata}), 32'({m_addr, m_wdata}));
            chk("gnt_id", 32'(bus.gnt_id), 32'(m_gnt));
            if (bus.c_ack || bus.h_ack) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_ack", 32'({bus.c_ack, bus.h_ack}), 32'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_who", 32'({bus.h_ack, bus.c_ack}), e.who ? 32'd2 : 32'd1);
                    chk("ack_cycle", cyc, e.ack_edge);
                    vis_c = e.c_rd;
                    vis_h = e.h_rd;
                end
            end
            if (exp_q.size() > 0 && exp_q[0].ack_edge < cyc) begin
                chk("ack_missing_at_cycle", cyc, exp_q[0].ack_edge);
                void'(exp_q.pop_front());
            end
            chk("c_rdata", 32'(bus.c_rdata), 32'(vis_c));
            chk("h_rdata", 32'(bus.h_rdata), 32'(vis_h));
        end
    end

    task automatic run_txn(input logic side, input logic we, input logic [7:0] a,
                           input logic [7:0] d, output int lat);
        if (side == HOST) begin
            bus.h_req = 1'b1; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d;
        end else begin
            bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d;
        end
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((side == HOST) ? bus.h_ack : bus.c_ack) begin
                lat = i;
                break;
            end
        end
        if (side == HOST) bus.h_req = 1'b0;
        else              bus.c_req = 1'b0;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: time limit reached, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         n;
        logic [3:0] seq;
        int         first;
        logic       c_done;
        logic       h_done;
        int         acks3;

        seed  = 8'($urandom);
        rst_n = 1'b0;
        bus.ena = 1'b1; bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
        bus3.ena = 1'b1; bus3.c_req = 1'b0; bus3.c_we = 1'b0; bus3.c_addr = '0; bus3.c_wdata = '0;
        bus3.h_req = 1'b0; bus3.h_we = 1'b0; bus3.h_addr = '0; bus3.h_wdata = '0;
        bus3.mem_rdata = 8'h30;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Core read 0x10 returning 0x5A.
        @(negedge clk);
        fix_en = 1'b1; fix_val = 8'h5A;
        run_txn(CORE, 1'b0, 8'h10, 8'h00, lat);
        chk("core_read_latency", lat, W + 2);
        chk("core_read_rdata", 32'(bus.c_rdata), 32'h5A);
        fix_en = 1'b0;

        // Host write 0x20 <- 0xC3.
        @(negedge clk);
        run_txn(HOST, 1'b1, 8'h20, 8'hC3, lat);
        chk("host_write_latency", lat, W + 2);
        chk("host_write_addr_data", 32'({bus.mem_addr, bus.mem_wdata}), 32'h20C3);
        chk("host_write_rdata_kept", 32'(bus.h_rdata), 32'h00);

        // Both requesting from reset: strict alternation starting with core.
        @(negedge clk);
        #1 rst_n = 1'b0;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h31;
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 8'h42;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        n = 0; seq = '0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (bus.c_ack || bus.h_ack) begin
                seq[n] = bus.h_ack;
                n++;
            end
        end
        bus.c_req = 1'b0; bus.h_req = 1'b0;
        chk("rr_ack_count", n, 4);
        chk("rr_order", 32'(seq), 32'b1010);

        // ena low holds off a pending core request.
        @(negedge clk);
        @(negedge clk);
        bus.ena = 1'b0;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ena_low_busy", 32'(bus.busy), 32'(0));
            chk("ena_low_ack", 32'(bus.c_ack), 32'(0));
        end
        bus.ena = 1'b1;
        run_txn(CORE, 1'b0, 8'h44, 8'h00, lat);
        chk("ena_release_latency", lat, W + 2);

        // Reset during ACCESS of a host write, then core-first grant.
        @(negedge clk);
        bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 8'h55; bus.h_wdata = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_oe", 32'(bus.mem_oe), 32'hFF);
        #1 rst_n = 1'b0;
        #1 chk("reset_oe_immediate", 32'({bus.mem_oe, bus.busy, bus.h_ack}), 32'(0));
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h66;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        first = -1; c_done = 1'b0; h_done = 1'b0;
        for (int i = 0; i < 40 && !(c_done && h_done); i++) begin
            @(negedge clk);
            if (bus.c_ack || bus.h_ack) begin
                if (first < 0) first = int'(bus.h_ack);
                if (bus.c_ack) begin c_done = 1'b1; bus.c_req = 1'b0; end
                if (bus.h_ack) begin h_done = 1'b1; bus.h_req = 1'b0; end
            end
        end
        bus.c_req = 1'b0; bus.h_req = 1'b0;
        chk("post_reset_first_grant", first, 0);
        chk("post_reset_both_served", 32'({c_done, h_done}), 32'b11);

        // Randomized traffic with ena dropouts.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            bus.ena = ($urandom_range(0, 7) != 0);
            if (bus.c_req && bus.c_ack) bus.c_req = 1'b0;
            if (!bus.c_req && $urandom_range(0, 2) == 0) begin
                bus.c_req = 1'b1; bus.c_we = 1'($urandom_range(0, 1));
                bus.c_addr = 8'($urandom); bus.c_wdata = 8'($urandom);
            end
            if (bus.h_req && bus.h_ack) bus.h_req = 1'b0;
            if (!bus.h_req && $urandom_range(0, 2) == 0) begin
                bus.h_req = 1'b1; bus.h_we = 1'($urandom_range(0, 1));
                bus.h_addr = 8'($urandom); bus.h_wdata = 8'($urandom);
            end
        end
        bus.ena = 1'b1;
        for (int i = 0; i < 40 && (bus.c_req || bus.h_req); i++) begin
            @(negedge clk);
            if (bus.c_ack) bus.c_req = 1'b0;
            if (bus.h_ack) bus.h_req = 1'b0;
        end
        repeat (W + 8) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        // Three wait cycles: capture must use the last ACCESS cycle's data.
        @(negedge clk);
        bus3.c_req = 1'b1; bus3.c_we = 1'b0; bus3.c_addr = 8'h10;
        lat = 0; acks3 = 0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            chk("w3_mem_oe", 32'(bus3.mem_oe), 32'(0));
            if (bus3.c_ack) begin
                acks3++;
                if (lat == 0) lat = j;
                bus3.c_req = 1'b0;
            end
            bus3.mem_rdata = 8'(8'h30 + j);
        end
        chk("w3_latency", lat, W3 + 2);
        chk("w3_ack_pulses", acks3, 1);
        chk("w3_rdata", 32'(bus3.c_rdata), 32'h34);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1; number of ACCESS cycles per transaction, legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  high permits new grants; low blocks new grants but lets an in-flight transaction finish.
REQ-005 c_req, c_we  input  1 each  core requester: request, write-not-read.
REQ-006 c_addr, c_wdata  input  8 each  core address and write data.
REQ-007 c_ack  output  1  core completion pulse; c_rdata  output  8  core read data.
REQ-008 h_req, h_we  input  1 each  host/loader requester: request, write-not-read.
REQ-009 h_addr, h_wdata  input  8 each  host address and write data.
REQ-010 h_ack  output  1  host completion pulse; h_rdata  output  8  host read data.
REQ-011 mem_addr  output  8  external memory address.
REQ-012 mem_wdata  output  8  external write data.
REQ-013 mem_rdata  input  8  external read data.
REQ-014 mem_oe  output  8  data-pin drive enable, all-ones when driving, all-zeros otherwise.
REQ-015 busy  output  1  high in any state other than IDLE; gnt_id  output  1  owner of current/last transaction (0 core, 1 host).

Function
REQ-016 FSM states IDLE, SETUP, ACCESS, DONE; one transaction in flight at a time.
REQ-017 IDLE: if ena and any req, select winner, latch its we/addr/wdata, go SETUP; otherwise stay IDLE.
REQ-018 Arbitration round-robin: with both requesting, grant the requester not granted last; single requester always wins.
REQ-019 SETUP: drive latched address/data, mem_oe per latched we, load wait counter with WAIT_CYCLES, go ACCESS next cycle.
REQ-020 ACCESS: decrement counter each cycle; on the cycle counter reaches 1, capture mem_rdata (reads only), go DONE.
REQ-021 DONE: pulse winner's ack high for exactly one cycle, mem_oe all-zeros, return IDLE.
REQ-022 Latency: req sampled at edge N gives ack high during cycle N+WAIT_CYCLES+2; back-to-back throughput one transaction per WAIT_CYCLES+3 cycles.
REQ-023 Requester holds req, we, addr, wdata stable until its ack; req dropped before ack is a protocol violation, transaction still completes.
REQ-024 rdata for a read is valid in the ack cycle and holds until that requester's next read completes; writes leave rdata unchanged.
REQ-025 mem_oe all-ones only in SETUP and ACCESS of a write; never asserted in IDLE or DONE.
REQ-026 mem_addr and mem_wdata hold the last latched values in IDLE and DONE (no toggling between transactions).
REQ-027 Loser's req is serviced on the next IDLE decision; no requester waits more than one foreign transaction.
REQ-028 Requests arriving during SETUP/ACCESS/DONE are not latched until the next IDLE cycle.
REQ-029 ena deasserted mid-transaction: transaction completes including ack; no further grants while low.
REQ-030 Wait counter is 4 bits; no wrap-around, ACCESS exits at count 1.

Reset
REQ-031 rst_n low asynchronously forces IDLE; all acks 0, both rdata 0, mem_addr 0, mem_wdata 0, mem_oe 0, busy 0, gnt_id 0, round-robin pointer favours core.
REQ-032 Reset mid-transaction aborts it with no ack; mem_oe drops to 0 immediately.
REQ-033 First grant after reset with both requesting goes to core.

Structure
REQ-034 Shared package holds FSM state encoding, requester ID constants (CORE=0, HOST=1), bus width 8, OE_ON/OE_OFF constants.
REQ-035 One sub-module rr_arbiter2: two requests plus last-grant pointer in, winner ID out; pointer register stays in mem_bus_arbiter.

Verification
REQ-036 WAIT_CYCLES=1, core read addr 0x10, mem_rdata=0x5A -> c_ack 3 cycles after req sampled, c_rdata=0x5A, mem_oe 0 throughout.
REQ-037 Host write addr 0x20 data 0xC3 -> mem_addr=0x20, mem_wdata=0xC3, mem_oe=0xFF in SETUP/ACCESS only, h_ack one pulse, h_rdata unchanged.
REQ-038 Both req held continuously from reset -> grants core, host, core, host; gnt_id alternates; each ack single-cycle.
REQ-039 WAIT_CYCLES=3, core read -> ack 5 cycles after req; rdata captured at last ACCESS cycle value, not earlier values.
REQ-040 rst_n low during ACCESS of host write -> mem_oe 0 same cycle, no h_ack, after release core-first grant.
REQ-041 ena low with pending c_req -> busy stays 0, no ack; ena high -> transaction starts next edge.
